// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: requester identity and reset owner.
package ram_arb_pkg;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    // B counts as last-granted out of reset so A wins the first contention.
    localparam owner_t ARB_RESET_LAST = OWN_B;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational round-robin arbiter; bit 0 = A, bit 1 = B.
// With RAM_ARB_LOCK_EN the last-granted requester may hold the grant via lock.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef RAM_ARB_LOCK_EN
    input  logic [1:0] lock,
`endif
    input  logic       last,
    output logic [1:0] gnt
);

    logic w_hold;

`ifdef RAM_ARB_LOCK_EN
    assign w_hold = lock[last];
`else
    assign w_hold = 1'b0;
`endif

    // On contention the non-last requester wins, unless the owner holds its lock.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ((last == OWN_B) ^ w_hold) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Shares one single-port RAM between requesters A and B with round-robin
// arbitration and a one-cycle read response strobe. Optional: RAM_ARB_LOCK_EN.
module ram_arbiter_2p
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
`ifdef RAM_ARB_LOCK_EN
    input  logic                  lock_a,
    input  logic                  lock_b,
`endif
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    owner_t     r_last_gnt;
    owner_t     r_rd_owner;
    logic       r_rd_valid;
    logic [1:0] w_gnt;
    owner_t     w_win;

    rr_arb2 u_arb (
        .req  ({req_b, req_a}),
`ifdef RAM_ARB_LOCK_EN
        .lock ({lock_b, lock_a}),
`endif
        .last (r_last_gnt),
        .gnt  (w_gnt)
    );

    assign gnt_a = w_gnt[0];
    assign gnt_b = w_gnt[1];
    assign w_win = w_gnt[1] ? OWN_B : OWN_A;

    // Idle cycles park the address on addr_a; the resulting RAM read is never reported.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = addr_a;
        ram_din  = '0;
        if (w_gnt[0]) begin
            ram_we   = we_a;
            ram_addr = addr_a;
            ram_din  = wdata_a;
        end else if (w_gnt[1]) begin
            ram_we   = we_b;
            ram_addr = addr_b;
            ram_din  = wdata_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= ARB_RESET_LAST;
            r_rd_valid <= 1'b0;
            r_rd_owner <= OWN_A;
        end else begin
            if (|w_gnt) begin
                r_last_gnt <= w_win;
            end
            r_rd_valid <= (|w_gnt) & ~ram_we;
            r_rd_owner <= w_win;
        end
    end

    assign rvalid_a = r_rd_valid & (r_rd_owner == OWN_A);
    assign rvalid_b = r_rd_valid & (r_rd_owner == OWN_B);
    assign rdata_a  = ram_dout;
    assign rdata_b  = ram_dout;

endmodule
